// File: rtl/kitchen_timer_pkg.sv
// Shared definitions for the multi-channel kitchen timer: channel states,
// active-low 7-segment codes (segments g..a) and the mm:ss load limits.
package kitchen_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } ch_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [5:0] MAX_SEC = 6'd59;

    // BCD digit to active-low segment pattern; anything above 9 is dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: holds mm:ss and its IDLE/RUN/PAUSED/DONE state.
// Command inputs arrive already qualified by channel select; any command
// in a cycle takes precedence over the shared 1 Hz tick.
module timer_channel
    import kitchen_timer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      start,
    input  logic      pause,
    input  logic      ack,
    input  logic      tick,
    input  logic [6:0] set_min,
    input  logic [5:0] set_sec,
    output logic [6:0] min,
    output logic [5:0] sec,
    output ch_state_t  state
);

    function automatic logic [6:0] sat_min(input logic [6:0] v);
        return (v > MAX_MIN) ? MAX_MIN : v;
    endfunction

    function automatic logic [5:0] sat_sec(input logic [5:0] v);
        return (v > MAX_SEC) ? MAX_SEC : v;
    endfunction

    logic is_zero;
    logic last_sec;

    assign is_zero  = (min == 7'd0) && (sec == 6'd0);
    // The coming decrement takes 00:01 to 00:00 and ends the countdown.
    assign last_sec = (min == 7'd0) && (sec == 6'd1);

    // Channel state machine with priority load > ack > start > pause > tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            min   <= 7'd0;
            sec   <= 6'd0;
        end else if (load) begin
            state <= IDLE;
            min   <= sat_min(set_min);
            sec   <= sat_sec(set_sec);
        end else if (ack) begin
            if (state == DONE) begin
                state <= IDLE;
                min   <= 7'd0;
                sec   <= 6'd0;
            end
        end else if (start) begin
            case (state)
                IDLE:    state <= is_zero ? DONE : RUN;
                PAUSED:  state <= RUN;
                default: state <= state;
            endcase
        end else if (pause) begin
            if (state == RUN) begin
                state <= PAUSED;
            end
        end else if (tick && (state == RUN)) begin
            if (sec != 6'd0) begin
                sec <= sec - 6'd1;
                if (last_sec) begin
                    state <= DONE;
                end
            end else if (min != 7'd0) begin
                sec <= MAX_SEC;
                min <= min - 7'd1;
            end else begin
                // 00:00 is terminal; a running channel should never sit here.
                state <= DONE;
            end
        end
    end

endmodule

// File: rtl/kitchen_timer_multi.sv
// N-channel mm:ss kitchen timer. Shared 1 Hz prescaler drives all channels;
// one multiplexed 4-digit active-low display shows the channel picked by
// disp_sel, blinking dark on alternate half-seconds while that channel is DONE.
module kitchen_timer_multi
    import kitchen_timer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [6:0]        set_min,
    input  logic [5:0]        set_sec,
    input  logic              start,
    input  logic              pause,
    input  logic              ack,
    input  logic [CH_W-1:0]   disp_sel,
    output logic [6:0]        cathode,
    output logic [3:0]        AN,
    output logic [NUM_CH-1:0] timeUp
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              blink_off;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_wrap;
    logic [1:0]        scan_idx;
    logic [CH_W-1:0]   disp_ch;

    logic [6:0]        ch_min   [NUM_CH];
    logic [5:0]        ch_sec   [NUM_CH];
    ch_state_t         ch_state [NUM_CH];

    logic [6:0]        sel_min;
    logic [5:0]        sel_sec;
    logic              sel_done;
    logic              sel_valid;
    logic [3:0]        digit_p0;
    logic              blank_p0;

    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign blink_off = (tick_cnt >= TICK_W'(TICK_DIV / 2));
    assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Free-running 1 Hz prescaler; commands never restart it
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = (ch_sel == CH_W'(i));

        timer_channel u_ch (
            .clk     (clk),
            .rst     (rst),
            .load    (load  & hit),
            .start   (start & hit),
            .pause   (pause & hit),
            .ack     (ack   & hit),
            .tick    (tick),
            .set_min (set_min),
            .set_sec (set_sec),
            .min     (ch_min[i]),
            .sec     (ch_sec[i]),
            .state   (ch_state[i])
        );
    end

    // Alarm outputs follow DONE one cycle behind the state
    always_ff @(posedge clk) begin
        if (rst) begin
            timeUp <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                timeUp[i] <= (ch_state[i] == DONE);
            end
        end
    end

    // Digit scan prescaler; the shown channel is re-latched at each slot boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            disp_ch  <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
            disp_ch  <= disp_sel;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Stage p0: pick the displayed channel and split its value into the current digit
    always_comb begin
        sel_min   = 7'd0;
        sel_sec   = 6'd0;
        sel_done  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (disp_ch == CH_W'(i)) begin
                sel_min   = ch_min[i];
                sel_sec   = ch_sec[i];
                sel_done  = (ch_state[i] == DONE);
                sel_valid = 1'b1;
            end
        end

        case (scan_idx)
            2'd0:    digit_p0 = 4'(sel_sec % 6'd10);
            2'd1:    digit_p0 = 4'(sel_sec / 6'd10);
            2'd2:    digit_p0 = 4'(sel_min % 7'd10);
            default: digit_p0 = 4'(sel_min / 7'd10);
        endcase

        blank_p0 = !sel_valid || (sel_done && blink_off);
    end

    // Stage p1: registered segment and anode drive
    always_ff @(posedge clk) begin
        if (rst) begin
            cathode <= SEG_0;
            AN      <= 4'b1110;
        end else begin
            cathode <= blank_p0 ? SEG_BLANK : seg_decode(digit_p0);
            AN      <= ~(4'b0001 << scan_idx);
        end
    end

endmodule

// File: tb/tb_kitchen_timer_multi.sv
// Bench for kitchen_timer_multi: a seconds-remaining model predicts timeUp,
// AN and cathode every cycle; directed scenarios add literal expectations.
module tb_kitchen_timer_multi;

    localparam int NUM_CH   = 4;
    localparam int TICK_DIV = 10;
    localparam int SCAN_DIV = 2;
    localparam int CH_W     = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load = 1'b0, start = 1'b0, pause = 1'b0, ack = 1'b0;
    logic [CH_W-1:0]   ch_sel = '0, disp_sel = '0;
    logic [6:0]        set_min = '0;
    logic [5:0]        set_sec = '0;
    logic [6:0]        cathode;
    logic [3:0]        AN;
    logic [NUM_CH-1:0] timeUp;

    int checks = 0;
    int errors = 0;

    kitchen_timer_multi #(
        .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .ch_sel(ch_sel),
        .set_min(set_min), .set_sec(set_sec), .start(start), .pause(pause),
        .ack(ack), .disp_sel(disp_sel), .cathode(cathode), .AN(AN), .timeUp(timeUp)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] seg_blank = 7'h7F;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  rem  [NUM_CH];
    int  mode [NUM_CH];
    int  decs [NUM_CH];
    int  last_dec [NUM_CH];
    int  cyc = 0;
    int  mdisp = 0;
    int  m_idx, m_dch, m_mm, m_ss, m_dg;
    bit  m_tick;
    bit  model_ok = 1'b0;
    logic [6:0]        exp_cathode;
    logic [3:0]        exp_an;
    logic [NUM_CH-1:0] exp_tu;

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            decs[i] = 0;
            last_dec[i] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rem[i]  = 0;
                mode[i] = M_IDLE;
            end
            cyc         = 0;
            mdisp       = 0;
            exp_tu      = '0;
            exp_an      = 4'b1110;
            exp_cathode = seg_ref[0];
            model_ok    = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) exp_tu[i] = (mode[i] == M_DONE);
            m_idx  = (cyc / SCAN_DIV) % 4;
            m_dch  = mdisp;
            exp_an = 4'hF;
            exp_an[m_idx] = 1'b0;
            if (m_dch >= NUM_CH || (mode[m_dch] == M_DONE && (cyc % TICK_DIV) >= TICK_DIV / 2)) begin
                exp_cathode = seg_blank;
            end else begin
                m_mm = rem[m_dch] / 60;
                m_ss = rem[m_dch] % 60;
                case (m_idx)
                    0:       m_dg = m_ss % 10;
                    1:       m_dg = m_ss / 10;
                    2:       m_dg = m_mm % 10;
                    default: m_dg = m_mm / 10;
                endcase
                exp_cathode = seg_ref[m_dg];
            end
            if (cyc % SCAN_DIV == SCAN_DIV - 1) mdisp = int'(disp_sel);
            m_tick = (cyc % TICK_DIV == TICK_DIV - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(ch_sel) == i && load) begin
                    rem[i]  = ((set_min > 99) ? 99 : int'(set_min)) * 60
                            + ((set_sec > 59) ? 59 : int'(set_sec));
                    mode[i] = M_IDLE;
                end else if (int'(ch_sel) == i && ack) begin
                    if (mode[i] == M_DONE) begin
                        mode[i] = M_IDLE;
                        rem[i]  = 0;
                    end
                end else if (int'(ch_sel) == i && start) begin
                    if (mode[i] == M_IDLE) mode[i] = (rem[i] != 0) ? M_RUN : M_DONE;
                    else if (mode[i] == M_PAUSE) mode[i] = M_RUN;
                end else if (int'(ch_sel) == i && pause) begin
                    if (mode[i] == M_RUN) mode[i] = M_PAUSE;
                end else if (m_tick && mode[i] == M_RUN) begin
                    rem[i]      = rem[i] - 1;
                    decs[i]     = decs[i] + 1;
                    last_dec[i] = cyc + 1;
                    if (rem[i] == 0) mode[i] = M_DONE;
                end
            end
            cyc = cyc + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            check("timeUp", 32'(timeUp), 32'(exp_tu));
            check("AN", 32'(AN), 32'(exp_an));
            check("cathode", 32'(cathode), 32'(exp_cathode));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [6:0] cap [4];

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int kind, input int ch, input int mn, input int sc);
        ch_sel  = CH_W'(ch);
        set_min = 7'(mn);
        set_sec = 6'(sc);
        case (kind)
            0:       load  = 1'b1;
            1:       start = 1'b1;
            2:       pause = 1'b1;
            default: ack   = 1'b1;
        endcase
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
    endtask

    task automatic wait_decs(input string name, input int ch, input int target);
        int n;
        n = 0;
        while (decs[ch] < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(decs[ch]), 32'(target));
    endtask

    task automatic wait_tu(input string name, input int ch, input int budget);
        int n;
        n = 0;
        while (timeUp[ch] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(timeUp[ch]), 32'd1);
    endtask

    task automatic capture(input int ch);
        disp_sel = CH_W'(ch);
        for (int d = 0; d < 4; d++) cap[d] = 'x;
        cycles(12);
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 4; d++) begin
                if (AN == ~(4'b0001 << d)) cap[d] = cathode;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_disp(input string name, input int d3, input int d2, input int d1, input int d0);
        check({name, "_d3"}, 32'(cap[3]), 32'(seg_ref[d3]));
        check({name, "_d2"}, 32'(cap[2]), 32'(seg_ref[d2]));
        check({name, "_d1"}, 32'(cap[1]), 32'(seg_ref[d1]));
        check({name, "_d0"}, 32'(cap[0]), 32'(seg_ref[d0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    int saved_decs [NUM_CH];

    initial begin
        // 1. reset
        rst = 1'b1;
        cycles(2);
        check("rst_timeUp", 32'(timeUp), 32'd0);
        check("rst_AN", 32'(AN), 32'b1110);
        check("rst_cathode", 32'(cathode), 32'b1000000);
        rst = 1'b0;
        capture(0);
        check_disp("rst_ch0", 0, 0, 0, 0);

        // 2. ch0 01:02 counts down to DONE
        disp_sel = 2'd0;
        pulse(0, 0, 1, 2);
        pulse(1, 0, 0, 0);
        wait_decs("ch0_t1", 0, 1);
        check("ch0_0101", 32'(rem[0]), 32'd61);
        wait_decs("ch0_t2", 0, 2);
        check("ch0_0100", 32'(rem[0]), 32'd60);
        wait_decs("ch0_t3", 0, 3);
        check("ch0_0059", 32'(rem[0]), 32'd59);
        wait_tu("ch0_done", 0, 700);
        check("ch0_ticks", 32'(decs[0]), 32'd62);
        check("ch0_tu_lat", 32'(cyc - last_dec[0]), 32'd1);

        // 3. ch1 05:00, pause after 3 ticks, hold, resume
        pulse(0, 1, 5, 0);
        pulse(1, 1, 0, 0);
        wait_decs("ch1_t3", 1, 3);
        pulse(2, 1, 0, 0);
        check("ch1_0457", 32'(rem[1]), 32'd297);
        cycles(200);
        check("ch1_hold", 32'(decs[1]), 32'd3);
        capture(1);
        check_disp("ch1_paused", 0, 4, 5, 7);
        pulse(1, 1, 0, 0);
        wait_decs("ch1_t4", 1, 4);
        check("ch1_0456", 32'(rem[1]), 32'd296);

        // 4. clamp on load, start at 00:00
        pulse(0, 2, 120, 63);
        check("ch2_clamp", 32'(rem[2]), 32'd5999);
        capture(2);
        check_disp("ch2_clamp", 9, 9, 5, 9);
        pulse(0, 2, 0, 0);
        pulse(1, 2, 0, 0);
        check("ch2_tu_pre", 32'(timeUp[2]), 32'd0);
        cycles(1);
        check("ch2_tu", 32'(timeUp[2]), 32'd1);
        cycles(20);

        // 5. ack of a DONE channel, then ack beats start
        pulse(0, 3, 0, 2);
        pulse(1, 3, 0, 0);
        wait_tu("ch3_done", 3, 60);
        pulse(3, 3, 0, 0);
        check("ch3_tu_hold", 32'(timeUp[3]), 32'd1);
        cycles(1);
        check("ch3_ack", 32'(timeUp[3]), 32'd0);
        ch_sel = 2'd3;
        start  = 1'b1;
        ack    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
        cycles(3);
        check("ch3_ack_wins", 32'(timeUp[3]), 32'd0);
        check("ch3_idle", 32'(mode[3]), 32'(M_IDLE));

        // 6. reset in the middle of counting
        pulse(0, 0, 2, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 3, 1, 0);
        pulse(1, 3, 0, 0);
        cycles(25);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_timeUp", 32'(timeUp), 32'd0);
        for (int i = 0; i < NUM_CH; i++) saved_decs[i] = decs[i];
        cycles(50);
        for (int i = 0; i < NUM_CH; i++) begin
            check("rst2_rem", 32'(rem[i]), 32'd0);
            check("rst2_nodec", 32'(decs[i]), 32'(saved_decs[i]));
        end
        capture(0);
        check_disp("rst2_ch0", 0, 0, 0, 0);
        capture(1);
        check_disp("rst2_ch1", 0, 0, 0, 0);
        check("rst2_timeUp_late", 32'(timeUp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
